// File: rtl/cacheline_adaptor_pkg.sv
// ----------------------------------------------------------------------------
// cacheline_adaptor_pkg
// Shared cache-side definitions for the line <-> burst adaptor.
//   - Default geometry: LINE_W (cache line bits), BURST_W (memory beat bits),
//     ADDR_W (byte address bits).
//   - Derived constants: BEATS (beats per line), OFFS (line offset bits).
//   - mem_state_t: adaptor FSM states.
//   - cnt_width(): width of a counter that indexes every beat of a line.
// No ports (package).
// ----------------------------------------------------------------------------
package cacheline_adaptor_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int ADDR_W  = 32;

  // Beats per cache line and number of byte-offset bits inside one line.
  localparam int BEATS = LINE_W / BURST_W;
  localparam int OFFS  = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  // A single-beat line still needs a 1-bit counter so the vectors stay legal.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage : cacheline_adaptor_pkg

// File: rtl/cacheline_adaptor_if.sv
// ----------------------------------------------------------------------------
// cacheline_adaptor_if
// Bundles the cache-side and memory-side signals of the line adaptor.
//   Cache side : read_i, write_i, address_i, line_i  -> adaptor
//                line_o, resp_o                      <- adaptor
//   Memory side: burst_i, resp_i                     -> adaptor
//                address_o, read_o, write_o, burst_o <- adaptor
// Modports:
//   slave  - the adaptor's view.
//   master - the environment's view (cache controller plus memory model).
// ----------------------------------------------------------------------------
interface cacheline_adaptor_if #(
  parameter int LINE_W  = cacheline_adaptor_pkg::LINE_W,
  parameter int BURST_W = cacheline_adaptor_pkg::BURST_W,
  parameter int ADDR_W  = cacheline_adaptor_pkg::ADDR_W
);

  // Cache side
  logic                read_i;
  logic                write_i;
  logic [ADDR_W-1:0]   address_i;
  logic [LINE_W-1:0]   line_i;
  logic [LINE_W-1:0]   line_o;
  logic                resp_o;

  // Memory side
  logic [ADDR_W-1:0]   address_o;
  logic                read_o;
  logic                write_o;
  logic [BURST_W-1:0]  burst_o;
  logic [BURST_W-1:0]  burst_i;
  logic                resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, address_o, read_o, write_o, burst_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, address_o, read_o, write_o, burst_o
  );

endinterface : cacheline_adaptor_if

// File: rtl/cacheline_adaptor.sv
// ----------------------------------------------------------------------------
// cacheline_adaptor
// Moves one whole cache line between the cache data array and memory as a
// sequence of BEATS narrow bursts. One transaction outstanding at a time; the
// cache holds its request until resp_o pulses for one cycle.
//
// Ports:
//   clk          clock, all state changes on posedge
//   rst          synchronous active-high reset (aborts any transaction)
//   bus (slave)  cache side : read_i, write_i, address_i, line_i,
//                             line_o (filled line), resp_o (done pulse)
//                memory side: address_o (line aligned), read_o, write_o,
//                             burst_o (write beat), burst_i (read beat),
//                             resp_i (one beat per high cycle)
//
// Beat 0 always carries the least-significant BURST_W bits of the line.
// ----------------------------------------------------------------------------
module cacheline_adaptor #(
  parameter int LINE_W  = cacheline_adaptor_pkg::LINE_W,
  parameter int BURST_W = cacheline_adaptor_pkg::BURST_W,
  parameter int ADDR_W  = cacheline_adaptor_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  cacheline_adaptor_if.slave   bus
);

  import cacheline_adaptor_pkg::*;

  localparam int LINE_BEATS = LINE_W / BURST_W;
  localparam int OFFS_BITS  = $clog2(LINE_W / 8);
  localparam int CNT_W      = cnt_width(LINE_BEATS);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  mem_state_t          r_state;
  mem_state_t          w_state_next;

  logic [CNT_W-1:0]    r_cnt;       // index of the beat currently on the bus
  logic [ADDR_W-1:0]   r_addr;      // latched, line-aligned address
  logic [LINE_W-1:0]   r_wline;     // line captured for write-back
  logic [LINE_W-1:0]   r_rbuf;      // fill line under assembly
  logic [LINE_W-1:0]   r_line;      // last completed fill, visible on line_o

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic                w_beat;      // memory accepted/delivered a beat
  logic                w_last;      // current beat is the final one
  logic [ADDR_W-1:0]   w_addr_aligned;
  logic [BURST_W-1:0]  w_wslice [LINE_BEATS];
  logic [LINE_W-1:0]   w_fill_line; // r_rbuf with the current beat merged in

  logic                w_read_o;
  logic                w_write_o;
  logic                w_resp_o;
  logic [BURST_W-1:0]  w_burst_o;

  assign w_beat = bus.resp_i;
  assign w_last = (r_cnt == LAST_BEAT);

  // Offset bits of the cache address carry no meaning for a whole-line access.
  assign w_addr_aligned = {bus.address_i[ADDR_W-1:OFFS_BITS], {OFFS_BITS{1'b0}}};

  logic w_unused_offs;
  assign w_unused_offs = ^bus.address_i[OFFS_BITS-1:0];

  // Split the write line into beats, and build the next fill line so that the
  // final beat can go straight into r_line without waiting a cycle.
  generate
    for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_beat
      assign w_wslice[gi] = r_wline[gi*BURST_W +: BURST_W];

      assign w_fill_line[gi*BURST_W +: BURST_W] =
        (r_cnt == CNT_W'(gi)) ? bus.burst_i : r_rbuf[gi*BURST_W +: BURST_W];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_read_o     = 1'b0;
    w_write_o    = 1'b0;
    w_resp_o     = 1'b0;
    w_burst_o    = '0;

    unique case (r_state)
      IDLE: begin
        // Write-back is taken first so a dirty victim leaves before the fill.
        if (bus.write_i) begin
          w_state_next = WRITE;
        end else if (bus.read_i) begin
          w_state_next = READ;
        end
      end

      READ: begin
        w_read_o = 1'b1;
        if (w_beat && w_last) begin
          w_state_next = DONE;
        end
      end

      WRITE: begin
        w_write_o = 1'b1;
        w_burst_o = w_wslice[r_cnt];
        if (w_beat && w_last) begin
          w_state_next = DONE;
        end
      end

      DONE: begin
        // The cache drops its request on this same edge, so IDLE will not
        // see a stale request.
        w_resp_o     = 1'b1;
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: address/line latches, beat counter, fill assembly
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rbuf  <= '0;
      r_line  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.write_i) begin
            r_addr  <= w_addr_aligned;
            r_wline <= bus.line_i;
          end else if (bus.read_i) begin
            r_addr  <= w_addr_aligned;
          end
        end

        READ: begin
          if (w_beat) begin
            r_rbuf <= w_fill_line;
            if (w_last) begin
              // line_o changes only once the whole line has arrived.
              r_line <= w_fill_line;
              r_cnt  <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        WRITE: begin
          if (w_beat) begin
            if (w_last) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          r_cnt <= '0;
        end

        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output mapping
  // --------------------------------------------------------------------------
  assign bus.read_o    = w_read_o;
  assign bus.write_o   = w_write_o;
  assign bus.resp_o    = w_resp_o;
  assign bus.burst_o   = w_burst_o;
  assign bus.address_o = r_addr;
  assign bus.line_o    = r_line;

endmodule : cacheline_adaptor

// File: tb/tb_cacheline_adaptor.sv
// ----------------------------------------------------------------------------
// tb_cacheline_adaptor
// Directed, table-driven bench for cacheline_adaptor. The bench plays both the
// cache controller and the memory. Inputs change and outputs are sampled on
// the falling clock edge.
// ----------------------------------------------------------------------------
module tb_cacheline_adaptor;

  import cacheline_adaptor_pkg::*;

  localparam int LW = LINE_W;
  localparam int BW = BURST_W;
  localparam int AW = ADDR_W;
  localparam int NB = BEATS;
  localparam int NV = 6;
  localparam int MAX_CYC = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cacheline_adaptor_if #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) bus ();

  cacheline_adaptor #(.LINE_W(LW), .BURST_W(BW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           rd;
    logic           wr;
    logic [AW-1:0]  addr;
    logic [LW-1:0]  wline;     // line offered for write-back
    logic [LW-1:0]  rline;     // line the memory returns (beat 0 = low bits)
    logic [15:0]    pat;       // resp_i per cycle after acceptance, bit 0 first
    int             plen;      // pattern length; resp_i stays high afterwards
    logic [AW-1:0]  exp_addr;  // expected address_o
  } txn_t;

  txn_t          vec [NV];
  txn_t          post_rst;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [LW-1:0] line_model = '0;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Runs one transaction from a falling edge with the DUT in IDLE and returns
  // at the falling edge of the idle cycle that follows DONE.
  task automatic run_txn(input string tag, input txn_t t);
    logic exp_rd;
    logic exp_wr;
    int   k;
    int   cyc;
    bit   done;
    exp_wr = t.wr;
    exp_rd = t.rd & ~t.wr;
    bus.read_i    = t.rd;
    bus.write_i   = t.wr;
    bus.address_i = t.addr;
    bus.line_i    = t.wline;
    bus.resp_i    = 1'b1;               // must be ignored while IDLE
    bus.burst_i   = '1;
    k    = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      @(negedge clk);
      if (k < NB) begin
        chk({tag, " read_o"},    LW'(bus.read_o),    LW'(exp_rd));
        chk({tag, " write_o"},   LW'(bus.write_o),   LW'(exp_wr));
        chk({tag, " resp_o"},    LW'(bus.resp_o),    LW'(1'b0));
        chk({tag, " address_o"}, LW'(bus.address_o), LW'(t.exp_addr));
        chk({tag, " line_o"},    bus.line_o,         line_model);
        if (exp_wr) begin
          chk($sformatf("%s burst_o[%0d]", tag, k), LW'(bus.burst_o), LW'(t.wline[k*BW +: BW]));
        end
        // Cache inputs other than the request are don't-care once latched.
        bus.address_i = ~t.addr;
        bus.line_i    = ~t.wline;
        bus.resp_i    = (cyc < t.plen) ? t.pat[cyc] : 1'b1;
        bus.burst_i   = bus.resp_i ? t.rline[k*BW +: BW] : ~t.rline[k*BW +: BW];
        if (bus.resp_i) k++;
      end else begin
        if (exp_rd) line_model = t.rline;
        chk({tag, " done resp_o"},  LW'(bus.resp_o),  LW'(1'b1));
        chk({tag, " done read_o"},  LW'(bus.read_o),  LW'(1'b0));
        chk({tag, " done write_o"}, LW'(bus.write_o), LW'(1'b0));
        chk({tag, " done line_o"},  bus.line_o,       line_model);
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        bus.resp_i  = 1'b1;             // must be ignored in DONE
        bus.burst_i = '1;
        @(negedge clk);
        chk({tag, " idle resp_o"},  LW'(bus.resp_o),  LW'(1'b0));
        chk({tag, " idle read_o"},  LW'(bus.read_o),  LW'(1'b0));
        chk({tag, " idle write_o"}, LW'(bus.write_o), LW'(1'b0));
        chk({tag, " idle line_o"},  bus.line_o,       line_model);
        bus.resp_i = 1'b0;
        done = 1'b1;
      end
      cyc++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got no resp_o within %0d cycles, required completion", tag, MAX_CYC);
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
      bus.resp_i  = 1'b0;
    end
  endtask

  initial begin
    vec[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h1234_5678, wline: '0,
               rline: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
               pat: 16'h000F, plen: 4, exp_addr: 32'h1234_5660};
    vec[1] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1000, wline: '0,
               rline: {64'hDEAD_BEEF_0000_0004, 64'hDEAD_BEEF_0000_0003,
                       64'hDEAD_BEEF_0000_0002, 64'hDEAD_BEEF_0000_0001},
               pat: 16'b0000_0000_0101_1001, plen: 7, exp_addr: 32'h0000_1000};
    vec[2] = '{rd: 1'b0, wr: 1'b1, addr: 32'h8000_001F,
               wline: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
               rline: '0, pat: 16'h000F, plen: 4, exp_addr: 32'h8000_0000};
    vec[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_00A5,
               wline: {64'h0F0F_0F0F_0F0F_0F0F, 64'h1234_5678_9ABC_DEF0,
                       64'hFEDC_BA98_7654_3210, 64'h5555_5555_5555_5555},
               rline: '0, pat: 16'b0000_0000_0011_0101, plen: 6, exp_addr: 32'h0000_00A0};
    vec[4] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0000_0040,
               wline: {64'h0000_0000_0000_0D0D, 64'h0000_0000_0000_0C0C,
                       64'h0000_0000_0000_0B0B, 64'h0000_0000_0000_0A0A},
               rline: '0, pat: 16'h000F, plen: 4, exp_addr: 32'h0000_0040};
    vec[5] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_0080, wline: '0,
               rline: {64'h8080_0000_0000_0003, 64'h8080_0000_0000_0002,
                       64'h8080_0000_0000_0001, 64'h8080_0000_0000_0000},
               pat: 16'h000F, plen: 4, exp_addr: 32'h0000_0080};
    post_rst = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_3333, wline: '0,
                 rline: {64'h0123_4567_89AB_CDEF, 64'hCAFE_F00D_0000_0002,
                         64'h0BAD_C0DE_0000_0001, 64'hFACE_B00C_0000_0000},
                 pat: 16'h000F, plen: 4, exp_addr: 32'h0000_3320};

    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset read_o",    LW'(bus.read_o),    '0);
    chk("reset write_o",   LW'(bus.write_o),   '0);
    chk("reset resp_o",    LW'(bus.resp_o),    '0);
    chk("reset address_o", LW'(bus.address_o), '0);
    chk("reset burst_o",   LW'(bus.burst_o),   '0);
    chk("reset line_o",    bus.line_o,         '0);
    rst = 1'b0;
    @(negedge clk);

    // Table: fill, stalled fill, write-back, simultaneous request, and an
    // eviction followed immediately by a fill (one idle cycle between them).
    for (int i = 0; i < NV; i++) begin
      run_txn($sformatf("v%0d", i), vec[i]);
    end

    // Reset two beats into a fill: abort, no resp_o, line_o cleared.
    bus.read_i    = 1'b1;
    bus.address_i = 32'h0000_2222;
    bus.resp_i    = 1'b0;
    @(negedge clk);
    bus.resp_i  = 1'b1;
    bus.burst_i = 64'h9999_0000_0000_0000;
    @(negedge clk);
    bus.burst_i = 64'h9999_0000_0000_0001;
    @(negedge clk);
    chk("rst mid read_o",  LW'(bus.read_o),    LW'(1'b1));
    chk("rst mid address", LW'(bus.address_o), LW'(32'h0000_2220));
    rst = 1'b1;
    bus.burst_i = 64'h9999_0000_0000_0002;
    @(negedge clk);
    line_model = '0;
    chk("rst abort read_o",    LW'(bus.read_o),    '0);
    chk("rst abort write_o",   LW'(bus.write_o),   '0);
    chk("rst abort resp_o",    LW'(bus.resp_o),    '0);
    chk("rst abort address_o", LW'(bus.address_o), '0);
    chk("rst abort line_o",    bus.line_o,         line_model);
    rst = 1'b0;
    bus.read_i = 1'b0;
    bus.resp_i = 1'b1;
    bus.burst_i = 64'h9999_0000_0000_0003;
    @(negedge clk);
    chk("rst after resp_o", LW'(bus.resp_o), '0);
    chk("rst after read_o", LW'(bus.read_o), '0);
    bus.resp_i = 1'b0;
    run_txn("post_rst", post_rst);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cacheline_adaptor
